fp_multiplier_param: RTL

- Parametrised IEEE-754 binary multiplier; successor to the fixed single-precision multi-cycle FSM multiplier.
- Generic exponent and mantissa widths.
- Full subnormal input and output support, round-to-nearest-even, and IEEE exception flags.
- Sits behind the operand-issue logic and uses the same in_rdy / res_rdy pulse handshake, plus an explicit busy indication.

---
 rtl/fp_multiplier_param.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_multiplier_param.sv
// rtl/fp_multiplier_param.sv - parametrised IEEE-754 multiplier: multi-cycle FSM, subnormals, RNE, exception flags
module fp_multiplier_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] op1,
  input  logic [EXP_W+MAN_W:0] op2,
  input  logic                 in_rdy,
  output logic                 busy,
  output logic [EXP_W+MAN_W:0] res,
  output logic                 res_rdy,
  output logic [3:0]           flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 1;
  localparam int PW  = 2 * M;
  localparam int EW  = EXP_W + 2;
  localparam int UCW = $clog2(MAN_W + 3) + 1;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  // Bits of the product below the round position; they only feed sticky.
  localparam logic [PW-1:0] LOW_MASK = (PW'(1) << (MAN_W - 2)) - PW'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_PRENORM, S_MUL,
    S_NORM, S_UNDER, S_ROUND, S_PACK, S_OUT
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]           a_q, b_q;
  logic                   sign_q;
  logic [M-1:0]           m1_q, m2_q;
  logic signed [EW-1:0]   e1_q, e2_q, exp_q;
  logic [PW-1:0]          prod_q;
  logic                   sticky_q, tiny_q, inexact_q;
  logic [UCW-1:0]         ucnt_q;
  logic [M-1:0]           rmant_q;
  logic [W-1:0]           pres_q;
  logic [3:0]             pflags_q;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic is_special, any_sub, inf_zero;

  // Classify the captured operands for the UNPACK/SPECIAL decisions
  always_comb begin
    a_exp      = a_q[W-2:MAN_W];
    b_exp      = b_q[W-2:MAN_W];
    a_frac     = a_q[MAN_W-1:0];
    b_frac     = b_q[MAN_W-1:0];
    a_nan      = (&a_exp) & (|a_frac);
    b_nan      = (&b_exp) & (|b_frac);
    a_snan     = a_nan & ~a_frac[MAN_W-1];
    b_snan     = b_nan & ~b_frac[MAN_W-1];
    a_inf      = (&a_exp) & ~(|a_frac);
    b_inf      = (&b_exp) & ~(|b_frac);
    a_zero     = ~(|a_exp) & ~(|a_frac);
    b_zero     = ~(|b_exp) & ~(|b_frac);
    inf_zero   = (a_inf & b_zero) | (b_inf & a_zero);
    is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    any_sub    = ~(|a_exp) | ~(|b_exp);
  end

  logic [M-1:0]         m1_sh, m2_sh;
  logic signed [EW-1:0] exp_norm;
  logic                 guard_b, round_b, sticky_b, round_up;
  logic [M:0]           mant_rnd;
  logic [EXP_W-1:0]     pack_exp;

  // Per-state datapath helpers: prenormalise shift, normalise exponent, RNE increment, packed exponent
  always_comb begin
    m1_sh    = m1_q[MAN_W] ? m1_q : (m1_q << 1);
    m2_sh    = m2_q[MAN_W] ? m2_q : (m2_q << 1);
    exp_norm = prod_q[PW-1] ? exp_q + ONE : exp_q;
    guard_b  = prod_q[MAN_W-1];
    round_b  = prod_q[MAN_W-2];
    sticky_b = sticky_q | (|(prod_q & LOW_MASK));
    round_up = guard_b & (round_b | sticky_b | prod_q[MAN_W]);
    mant_rnd = {1'b0, prod_q[2*MAN_W:MAN_W]} + {{M{1'b0}}, round_up};
    pack_exp = rmant_q[MAN_W] ? exp_q[EXP_W-1:0] : {EXP_W{1'b0}};
  end

  logic accept;

  // FSM output decode: operands are taken only in IDLE while not busy
  always_comb begin
    accept = (state == S_IDLE) & ~busy & in_rdy;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (accept) state_nx = S_UNPACK;
      S_UNPACK:  state_nx = is_special ? S_SPECIAL : (any_sub ? S_PRENORM : S_MUL);
      S_SPECIAL: state_nx = S_OUT;
      S_PRENORM: if (m1_sh[MAN_W] & m2_sh[MAN_W]) state_nx = S_MUL;
      S_MUL:     state_nx = S_NORM;
      S_NORM:    state_nx = (exp_norm < ONE) ? S_UNDER : S_ROUND;
      S_UNDER:   if ((ucnt_q == UCW'(MAN_W + 2)) || !exp_q[EW-1]) state_nx = S_ROUND;
      S_ROUND:   state_nx = S_PACK;
      S_PACK:    state_nx = S_OUT;
      S_OUT:     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Datapath and output registers, advanced by the current FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0; b_q <= '0; sign_q <= 1'b0;
      m1_q <= '0; m2_q <= '0; e1_q <= '0; e2_q <= '0; exp_q <= '0;
      prod_q <= '0; sticky_q <= 1'b0; tiny_q <= 1'b0; inexact_q <= 1'b0;
      ucnt_q <= '0; rmant_q <= '0; pres_q <= '0; pflags_q <= '0;
      res <= '0; flags <= '0; res_rdy <= 1'b0; busy <= 1'b0;
    end else begin
      res_rdy <= 1'b0;
      if (accept) begin
        a_q  <= op1;
        b_q  <= op2;
        busy <= 1'b1;
      end else if (res_rdy) begin
        busy <= 1'b0;
      end
      case (state)
        S_UNPACK: begin
          sign_q   <= a_q[W-1] ^ b_q[W-1];
          m1_q     <= {|a_exp, a_frac};
          m2_q     <= {|b_exp, b_frac};
          e1_q     <= (|a_exp) ? {2'b00, a_exp} : ONE;
          e2_q     <= (|b_exp) ? {2'b00, b_exp} : ONE;
          sticky_q <= 1'b0;
          tiny_q   <= 1'b0;
          ucnt_q   <= '0;
        end
        S_SPECIAL: begin
          if (a_nan | b_nan | inf_zero) begin
            pres_q   <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            pflags_q <= {inf_zero | a_snan | b_snan, 3'b000};
          end else if (a_inf | b_inf) begin
            pres_q   <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pflags_q <= 4'b0000;
          end else begin
            pres_q   <= {sign_q, {(W-1){1'b0}}};
            pflags_q <= 4'b0000;
          end
        end
        S_PRENORM: begin
          m1_q <= m1_sh;
          m2_q <= m2_sh;
          if (!m1_q[MAN_W]) e1_q <= e1_q - ONE;
          if (!m2_q[MAN_W]) e2_q <= e2_q - ONE;
        end
        S_MUL: begin
          prod_q <= PW'(m1_q) * PW'(m2_q);
          exp_q  <= e1_q + e2_q - BIAS;
        end
        S_NORM: begin
          if (prod_q[PW-1]) begin
            prod_q   <= prod_q >> 1;
            sticky_q <= sticky_q | prod_q[0];
          end
          exp_q <= exp_norm;
        end
        S_UNDER: begin
          tiny_q <= 1'b1;
          if (ucnt_q == UCW'(MAN_W + 2)) begin
            // Everything would end up below the round bit: collapse to sticky only
            prod_q   <= '0;
            sticky_q <= 1'b1;
            exp_q    <= ONE;
          end else begin
            prod_q   <= prod_q >> 1;
            sticky_q <= sticky_q | prod_q[0];
            exp_q    <= exp_q + ONE;
            ucnt_q   <= ucnt_q + UCW'(1);
          end
        end
        S_ROUND: begin
          inexact_q <= guard_b | round_b | sticky_b;
          if (mant_rnd[M]) begin
            rmant_q <= mant_rnd[M:1];
            exp_q   <= exp_q + ONE;
          end else begin
            rmant_q <= mant_rnd[M-1:0];
          end
        end
        S_PACK: begin
          if (exp_q >= EMAX) begin
            pres_q   <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pflags_q <= 4'b0101;
          end else begin
            pres_q   <= {sign_q, pack_exp, rmant_q[MAN_W-1:0]};
            pflags_q <= {2'b00, tiny_q & inexact_q, inexact_q};
          end
        end
        S_OUT: begin
          res     <= pres_q;
          flags   <= pflags_q;
          res_rdy <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
